// File: rtl/drp_wb_pkg.sv
// drp_wb_pkg: shared types for the DRP -> Wishbone bridge.
//   drp_wb_state_t : bridge FSM states
//   timer_t        : 16-bit saturating watchdog timer
//   retry_t        : 8-bit retry counter
//   timer_inc()    : saturating increment for the watchdog
package drp_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_BACKOFF = 2'd2
  } drp_wb_state_t;

  localparam int TIMER_W = 16;
  localparam int RETRY_W = 8;

  typedef logic [TIMER_W-1:0] timer_t;
  typedef logic [RETRY_W-1:0] retry_t;

  // Hold at all-ones so a disabled watchdog can never wrap back into range.
  function automatic timer_t timer_inc(input timer_t t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/drp_wb.sv
// drp_wb: DRP slave port bridged onto a 16-bit Wishbone master.
// One transaction in flight, watchdog abort, WB retry handling.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   drp_addr/di/we/en         DRP request (sampled on drp_en)
//   drp_do, drp_rdy           DRP completion (drp_do is 0 unless drp_rdy)
//   wb_adr_o/dat_o/we_o/sel_o Wishbone request fields
//   wb_cyc_o, wb_stb_o        Wishbone cycle/strobe
//   wb_dat_i/ack_i/err_i/rty_i Wishbone response
//   status_err                pulses with drp_rdy on err/timeout/retry exhaustion
//   status_overrun            pulses when a drp_en was dropped because busy
module drp_wb
  import drp_wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int TIMEOUT     = 256,
  parameter int RETRY_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] drp_addr,
  input  logic [15:0]           drp_di,
  output logic [15:0]           drp_do,
  input  logic                  drp_en,
  input  logic                  drp_we,
  output logic                  drp_rdy,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  output logic                  wb_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  output logic                  wb_cyc_o,
  output logic                  status_err,
  output logic                  status_overrun
);

  localparam bit     TO_EN     = (TIMEOUT != 0);
  localparam timer_t TO_LAST   = timer_t'(TIMEOUT - 1);
  localparam retry_t RETRY_MAX = retry_t'(RETRY_COUNT);

  drp_wb_state_t state_q, state_d;
  timer_t        timer_q, timer_d;
  retry_t        rcnt_q, rcnt_d;

  // The drp_rdy cycle is still treated as busy even though the FSM is
  // already back in IDLE, so a request there is dropped, not accepted.
  logic can_accept, accept, busy_hit;
  assign can_accept = (state_q == ST_IDLE) && !drp_rdy;
  assign accept     = drp_en && can_accept;
  assign busy_hit   = drp_en && !can_accept;

  // Terminations only count while stb is up; ack > err > rty.
  logic term_ack, term_err, term_rty, timeout_hit, retry_ok, fail, backoff;
  assign term_ack    = wb_stb_o && wb_ack_i;
  assign term_err    = wb_stb_o && !wb_ack_i && wb_err_i;
  assign term_rty    = wb_stb_o && !wb_ack_i && !wb_err_i && wb_rty_i;
  assign timeout_hit = TO_EN && wb_stb_o && (timer_q == TO_LAST) &&
                       !wb_ack_i && !wb_err_i && !wb_rty_i;
  assign retry_ok    = rcnt_q < RETRY_MAX;
  assign fail        = term_err || (term_rty && !retry_ok) || timeout_hit;
  assign backoff     = term_rty && retry_ok;

  // State / counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACTIVE;
          timer_d = '0;
          rcnt_d  = '0;
        end
      end
      ST_ACTIVE: begin
        timer_d = timer_inc(timer_q);
        if (term_ack || fail) begin
          state_d = ST_IDLE;
        end else if (backoff) begin
          state_d = ST_BACKOFF;
          rcnt_d  = rcnt_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        state_d = ST_ACTIVE;
        timer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  logic                  cyc_d, we_d, rdy_d, err_d, ovr_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [15:0]           wdat_d, rdat_d;

  always_comb begin
    cyc_d  = wb_cyc_o;
    adr_d  = wb_adr_o;
    wdat_d = wb_dat_o;
    we_d   = wb_we_o;
    rdy_d  = 1'b0;
    rdat_d = 16'h0000;
    err_d  = 1'b0;
    ovr_d  = busy_hit;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          adr_d  = drp_addr;
          wdat_d = drp_di;
          we_d   = drp_we;
          cyc_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (term_ack) begin
          cyc_d  = 1'b0;
          rdy_d  = 1'b1;
          rdat_d = wb_we_o ? 16'h0000 : wb_dat_i;
        end else if (fail) begin
          cyc_d = 1'b0;
          rdy_d = 1'b1;
          err_d = 1'b1;
        end else if (backoff) begin
          cyc_d = 1'b0;
        end
      end
      ST_BACKOFF: cyc_d = 1'b1;
      default:    cyc_d = 1'b0;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_sel_o       <= 2'b00;
      wb_adr_o       <= '0;
      wb_dat_o       <= 16'h0000;
      wb_we_o        <= 1'b0;
      drp_rdy        <= 1'b0;
      drp_do         <= 16'h0000;
      status_err     <= 1'b0;
      status_overrun <= 1'b0;
    end else begin
      wb_cyc_o       <= cyc_d;
      wb_stb_o       <= cyc_d;
      wb_sel_o       <= {2{cyc_d}};
      wb_adr_o       <= adr_d;
      wb_dat_o       <= wdat_d;
      wb_we_o        <= we_d;
      drp_rdy        <= rdy_d;
      drp_do         <= rdat_d;
      status_err     <= err_d;
      status_overrun <= ovr_d;
    end
  end

endmodule

// File: tb/tb_drp_wb.sv
// tb_drp_wb: randomized self-checking bench for drp_wb. A scripted WB slave
// answers each bus attempt; a transaction-level model predicts latency,
// read data, error status and number of bus attempts.
module tb_drp_wb;

  localparam int AW = 16;
  localparam int TO = 16;
  localparam int RC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] drp_addr = '0;
  logic [15:0]   drp_di = '0;
  logic [15:0]   drp_do;
  logic          drp_en = 1'b0;
  logic          drp_we = 1'b0;
  logic          drp_rdy;
  logic [AW-1:0] wb_adr_o;
  logic [15:0]   wb_dat_i = '0;
  logic [15:0]   wb_dat_o;
  logic          wb_we_o;
  logic [1:0]    wb_sel_o;
  logic          wb_stb_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          wb_rty_i = 1'b0;
  logic          wb_cyc_o;
  logic          status_err;
  logic          status_overrun;

  drp_wb #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .RETRY_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
    .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_cyc_o(wb_cyc_o), .status_err(status_err), .status_overrun(status_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave script: per bus attempt, response mask {rty,err,ack} (0 = silent)
  // given after dly stb cycles (0 = same cycle as stb rises).
  logic [2:0]  msk[4];
  int          dly[4];
  logic [15:0] rdata;

  int          e_lat, e_att;
  logic [15:0] e_do;
  logic        e_err;

  // Transaction-level prediction. Latency counts clocks from the drp_en cycle
  // (cycle 0) to the drp_rdy cycle; the first strobe cycle is cycle 1.
  task automatic model(input logic we);
    int start, retries, s;
    start = 1; retries = 0;
    e_lat = 0; e_att = 0; e_do = 16'h0000; e_err = 1'b0;
    for (int a = 0; a < 4; a++) begin
      s = (msk[a] == 3'b000) ? TO : dly[a] + 1;
      e_att = a + 1;
      if (msk[a][0]) begin
        e_lat = start + s; e_do = we ? 16'h0000 : rdata; e_err = 1'b0;
        break;
      end else if (msk[a] == 3'b100 && retries < RC) begin
        retries++;
        start += s + 1;   // one idle backoff cycle before the reissue
      end else begin
        e_lat = start + s; e_do = 16'h0000; e_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_script(input logic [2:0] m0, m1, m2, m3, input int d0, d1, d2, d3);
    msk[0] = m0; msk[1] = m1; msk[2] = m2; msk[3] = m3;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic gen_rand();
    int r;
    logic [1:0] ex;
    logic [2:0] base;
    for (int a = 0; a < 4; a++) begin
      r  = $urandom_range(0, 19);
      ex = 2'($urandom);
      if (r < 9)       base = 3'b001;
      else if (r < 12) base = 3'b010;
      else if (r < 18) base = 3'b100;
      else             base = 3'b000;
      if (base == 3'b001)      msk[a] = base | {ex, 1'b0};
      else if (base == 3'b010) msk[a] = base | {ex[0], 2'b00};
      else                     msk[a] = base;
      dly[a] = $urandom_range(0, 4);
    end
    rdata = 16'($urandom);
  endtask

  // Runs one DRP transaction starting at the current negedge. ovr_at < 0:
  // no extra request; otherwise a second drp_en in that cycle (clamped to the
  // drp_rdy cycle). Returns at the negedge of the cycle after drp_rdy.
  task automatic run_txn(input string nm, input logic [AW-1:0] addr,
                         input logic [15:0] di, input logic we, input int ovr_at_in);
    int c, att, scnt, lat, ovr_at;
    logic prev_stb, done, got_err;
    logic [15:0] got_do;
    model(we);
    ovr_at = (ovr_at_in > e_lat) ? e_lat : ovr_at_in;
    drp_addr = addr; drp_di = di; drp_we = we; drp_en = 1'b1;
    prev_stb = 1'b0; att = 0; scnt = 0; lat = -1; done = 1'b0;
    got_do = 16'h0000; got_err = 1'b0;
    for (c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      checks++;
      if (status_overrun !== (c - 1 == ovr_at)) begin
        failures++;
        $display("FAIL %s overrun c=%0d got %b want %b", nm, c, status_overrun, (c - 1 == ovr_at));
      end
      if (wb_stb_o && !prev_stb) begin att++; scnt = 0; end
      checks++;
      if (wb_cyc_o) begin
        if ({wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o, wb_we_o} !== {1'b1, 2'b11, addr, di, we}) begin
          failures++;
          $display("FAIL %s bus c=%0d got stb=%b sel=%b adr=%h dat=%h we=%b want 1/11/%h/%h/%b",
                   nm, c, wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o, wb_we_o, addr, di, we);
        end
      end else if ({wb_stb_o, wb_sel_o} !== 3'b000) begin
        failures++;
        $display("FAIL %s idle_bus c=%0d got stb=%b sel=%b want 0/00", nm, c, wb_stb_o, wb_sel_o);
      end
      if (drp_rdy) begin
        lat = c; got_do = drp_do; got_err = status_err; done = 1'b1;
      end else begin
        checks++;
        if ({drp_do, status_err} !== 17'h0) begin
          failures++;
          $display("FAIL %s quiet c=%0d got do=%h err=%b want 0/0", nm, c, drp_do, status_err);
        end
      end
      prev_stb = wb_stb_o;
      // drive for the coming cycle
      drp_en = (c == ovr_at);
      if (drp_en) begin
        drp_addr = AW'($urandom); drp_di = 16'($urandom); drp_we = 1'($urandom);
      end
      wb_dat_i = 16'($urandom);
      {wb_rty_i, wb_err_i, wb_ack_i} = 3'b000;
      if (wb_stb_o) begin
        if (att >= 1 && att <= 4 && msk[att-1] != 3'b000 && scnt == dly[att-1]) begin
          {wb_rty_i, wb_err_i, wb_ack_i} = msk[att-1];
          if (msk[att-1][0]) wb_dat_i = rdata;
        end
        scnt++;
      end else begin
        {wb_rty_i, wb_err_i, wb_ack_i} = 3'($urandom);   // must be ignored
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s no_rdy got none within 300 cycles want rdy at %0d", nm, e_lat);
    end
    checks++;
    if (lat !== e_lat) begin
      failures++; $display("FAIL %s latency got %0d want %0d", nm, lat, e_lat);
    end
    checks++;
    if (got_do !== e_do) begin
      failures++; $display("FAIL %s drp_do got %h want %h", nm, got_do, e_do);
    end
    checks++;
    if (got_err !== e_err) begin
      failures++; $display("FAIL %s status_err got %b want %b", nm, got_err, e_err);
    end
    checks++;
    if (att !== e_att) begin
      failures++; $display("FAIL %s attempts got %0d want %0d", nm, att, e_att);
    end
    // cycle after drp_rdy: pulses gone, bus idle
    @(negedge clk);
    checks++;
    if ({drp_rdy, drp_do, status_err, wb_cyc_o, wb_stb_o, status_overrun} !==
        {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, (lat == ovr_at)}) begin
      failures++;
      $display("FAIL %s post got rdy=%b do=%h err=%b cyc=%b stb=%b ovr=%b want 0/0/0/0/0/%b",
               nm, drp_rdy, drp_do, status_err, wb_cyc_o, wb_stb_o, status_overrun, (lat == ovr_at));
    end
    drp_en = 1'b0;
    {wb_rty_i, wb_err_i, wb_ack_i} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drp_en = 1'b1; drp_addr = 16'h1111; drp_di = 16'h2222; drp_we = 1'b1;
    {wb_rty_i, wb_err_i, wb_ack_i} = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if ({drp_do, drp_rdy, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
         status_err, status_overrun} !== '0) begin
      failures++;
      $display("FAIL reset outputs got do=%h rdy=%b adr=%h dat=%h we=%b sel=%b stb=%b cyc=%b err=%b ovr=%b want all 0",
               drp_do, drp_rdy, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
               status_err, status_overrun);
    end
    drp_en = 1'b0; {wb_rty_i, wb_err_i, wb_ack_i} = 3'b000;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 2, 0, 0, 0);
    rdata = 16'hDEAD;
    run_txn("write", 16'h0012, 16'hBEEF, 1'b1, -1);
  endtask

  task automatic test_read();
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 0, 0, 0, 0);
    rdata = 16'h5A5A;
    run_txn("read", 16'h0034, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_retry();
    set_script(3'b100, 3'b100, 3'b001, 3'b001, 1, 0, 2, 0);
    rdata = 16'h1234;
    run_txn("retry_ok", 16'h0056, 16'h0000, 1'b0, -1);
    set_script(3'b100, 3'b100, 3'b100, 3'b100, 0, 1, 0, 2);
    rdata = 16'h4321;
    run_txn("retry_exhaust", 16'h0078, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_timeout();
    set_script(3'b000, 3'b001, 3'b001, 3'b001, 0, 0, 0, 0);
    run_txn("timeout", 16'h009A, 16'hCAFE, 1'b1, -1);
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0);
    rdata = 16'h0F0F;
    run_txn("after_timeout", 16'h00BC, 16'h0000, 1'b0, -1);
    set_script(3'b100, 3'b000, 3'b001, 3'b001, 0, 0, 0, 0);
    run_txn("retry_then_timeout", 16'h00BD, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_overrun();
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 3, 0, 0, 0);
    rdata = 16'hAAAA;
    run_txn("overrun_early", 16'h0101, 16'h0000, 1'b0, 1);
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0);
    run_txn("overrun_rdy", 16'h0202, 16'h5555, 1'b1, 999);
    set_script(3'b011, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0);
    rdata = 16'h7E7E;
    run_txn("ack_err_collide", 16'h0303, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    drp_addr = 16'h0404; drp_di = 16'h1357; drp_we = 1'b1; drp_en = 1'b1;
    @(negedge clk);
    drp_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1) begin
      failures++; $display("FAIL reset_mid pre_stb got %b want 1", wb_stb_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({drp_do, drp_rdy, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
         status_err, status_overrun} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs got rdy=%b adr=%h dat=%h cyc=%b stb=%b want all 0",
               drp_rdy, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o);
    end
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({drp_rdy, wb_cyc_o} !== 2'b00) begin
        failures++; $display("FAIL reset_mid abandoned got rdy=%b cyc=%b want 0/0", drp_rdy, wb_cyc_o);
      end
    end
    wb_ack_i = 1'b0;
    set_script(3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 0, 0);
    run_txn("post_reset_write", 16'h0505, 16'h2468, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      gen_rand();
      run_txn("b2b", AW'($urandom), 16'($urandom), 1'($urandom), -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      gen_rand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn("rand", AW'($urandom), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_retry();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
